// File: rtl/run_seq_pkg.sv
// Shared types for the run sequencer: FSM state encoding, the per-program
// result record, and a helper that sizes index buses.
package run_seq_pkg;

    // Widest cycle counter and program counter a result record can hold.
    // Narrower instances zero-extend into these fields.
    localparam int CYC_W_MAX = 32;
    localparam int PC_W_MAX  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_START,
        S_RUN,
        S_LOG,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [CYC_W_MAX-1:0] cycles;
        logic [PC_W_MAX-1:0]  pc;
        logic                 to;
    } result_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_seq_if.sv
// Core-control and result-read bundle of the run sequencer.
// The master side is the sequencer; the slave side is the core and the reader.
interface run_seq_if
    import run_seq_pkg::*;
#(
    parameter int NUM_PROGS = 4,
    parameter int CYC_W     = 16,
    parameter int PC_W      = 10
);
    localparam int IDX_W = idx_w(NUM_PROGS);

    logic             req;
    logic             core_ack;
    logic [PC_W-1:0]  core_pc;
    logic             core_reset;
    logic             core_start;
    logic [IDX_W-1:0] prog_sel;
    logic             busy;
    logic             done;
    logic             err;
    logic [IDX_W-1:0] rd_idx;
    logic [CYC_W-1:0] rd_cycles;
    logic [PC_W-1:0]  rd_pc;
    logic             rd_to;

    modport master (
        input  req, core_ack, core_pc, rd_idx,
        output core_reset, core_start, prog_sel, busy, done, err,
               rd_cycles, rd_pc, rd_to
    );

    modport slave (
        output req, core_ack, core_pc, rd_idx,
        input  core_reset, core_start, prog_sel, busy, done, err,
               rd_cycles, rd_pc, rd_to
    );

endinterface

// File: rtl/run_seq_results.sv
// Result register file: one entry per program, one synchronous write port,
// one combinational read port. A per-entry valid bit lets a new batch hide
// the previous batch's results in a single cycle.
module run_seq_results
    import run_seq_pkg::*;
#(
    parameter int NUM_PROGS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          we_i,
    input  logic [idx_w(NUM_PROGS)-1:0]   wr_idx_i,
    input  result_t                       wr_data_i,
    input  logic [idx_w(NUM_PROGS)-1:0]   rd_idx_i,
    output result_t                       rd_data_o
);

    result_t              mem_q [NUM_PROGS];
    logic [NUM_PROGS-1:0] vld_q;

    // Entry storage and valid bits; a write in the clear cycle never occurs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the result store is reset too, since a reset must leave no stale result readable.
        if (!rst_ni) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
                mem_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            if (clr_i) begin
                vld_q <= '0;
            end
            if (we_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
                vld_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Combinational read; out-of-range or invalid entries read as zero.
    always_comb begin
        rd_data_o = '0;
        if ((32'(rd_idx_i) < NUM_PROGS) && vld_q[rd_idx_i]) begin
            rd_data_o = mem_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Runs NUM_PROGS core programs back to back: reset the core, pulse start,
// time the run (with timeout), log cycles/PC/timeout per program.
// The interface instance must carry the same NUM_PROGS/CYC_W/PC_W.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int              NUM_PROGS = 4,
    parameter int              CYC_W     = 16,
    parameter int              PC_W      = 10,
    parameter int              RST_CYC   = 2,
    parameter longint unsigned TIMEOUT   = (64'd1 << CYC_W) - 64'd1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    run_seq_if.master   bus
);

    localparam int               IDX_W     = idx_w(NUM_PROGS);
    localparam int               RC_W      = idx_w(RST_CYC + 1);
    localparam logic [CYC_W-1:0] TO_LIM    = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] CNT_MAX   = '1;
    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RST_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_PROG = IDX_W'(NUM_PROGS - 1);

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             to_q, to_d;
    logic             err_q, err_d;
    logic             core_reset_q;
    logic             clr, we;
    result_t          wr_data, rd_data;
    logic             unused_rd;

    // Saturating run-cycle increment.
    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CYC_W'(1);

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        sel_d   = sel_q;
        to_d    = to_q;
        err_d   = err_q;
        clr     = 1'b0;
        we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = S_CRST;
                    sel_d   = '0;
                    err_d   = 1'b0;
                    rc_d    = '0;
                    clr     = 1'b1;
                end
            end
            S_CRST: begin
                if (rc_q == RC_LAST) begin
                    state_d = S_START;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                // An ack in the timeout cycle still counts as a clean finish.
                if (bus.core_ack) begin
                    state_d = S_LOG;
                    to_d    = 1'b0;
                end else if (cnt_inc >= TO_LIM) begin
                    state_d = S_LOG;
                    to_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_LOG: begin
                we = 1'b1;
                if (sel_q == LAST_PROG) begin
                    state_d = S_DONE;
                end else begin
                    sel_d   = sel_q + IDX_W'(1);
                    rc_d    = '0;
                    state_d = S_CRST;
                end
            end
            S_DONE: begin
                if (!bus.req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; core reset stays high out of reset until the first edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rc_q         <= '0;
            sel_q        <= '0;
            to_q         <= 1'b0;
            err_q        <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rc_q         <= rc_d;
            sel_q        <= sel_d;
            to_q         <= to_d;
            err_q        <= err_d;
            core_reset_q <= (state_d == S_CRST);
        end
    end

    assign wr_data = '{cycles: CYC_W_MAX'(cnt_q), pc: PC_W_MAX'(bus.core_pc), to: to_q};

    run_seq_results #(
        .NUM_PROGS (NUM_PROGS)
    ) u_results (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr),
        .we_i      (we),
        .wr_idx_i  (sel_q),
        .wr_data_i (wr_data),
        .rd_idx_i  (bus.rd_idx),
        .rd_data_o (rd_data)
    );

    // Upper record bits are always zero at these widths.
    assign unused_rd = ^rd_data;

    assign bus.core_reset = core_reset_q;
    assign bus.core_start = (state_q == S_START);
    assign bus.prog_sel   = sel_q;
    assign bus.busy       = state_q inside {S_CRST, S_START, S_RUN, S_LOG};
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;
    assign bus.rd_cycles  = rd_data.cycles[CYC_W-1:0];
    assign bus.rd_pc      = rd_data.pc[PC_W-1:0];
    assign bus.rd_to      = rd_data.to;

endmodule
